// File: rtl/enemy_sched_pkg.sv
// Shared constants and sprite position type for the enemy sprite scheduler.
package enemy_sched_pkg;
   localparam int SPR_W = 32;
   localparam int SPR_H = 32;
   localparam int IDX_W = 4;
   localparam int OX_W  = $clog2(SPR_W);
   localparam int OY_W  = $clog2(SPR_H);

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       en;
   } spr_pos_t;
endpackage

// File: rtl/sprite_hit_unit.sv
// Per-enemy hit test: reports coverage of the current pixel and the in-sprite offset.
module sprite_hit_unit
   import enemy_sched_pkg::*;
(
   input  logic [9:0]      DrawX,
   input  logic [9:0]      DrawY,
   input  spr_pos_t        pos,
   output logic            hit,
   output logic [OX_W-1:0] ox,
   output logic [OY_W-1:0] oy
);
   logic [9:0] dx;
   logic [9:0] dy;

   // Unsigned wrap makes pixels left of / above the sprite appear far away, hence a miss.
   always_comb begin
      dx  = DrawX - pos.x;
      dy  = DrawY - pos.y;
      hit = pos.en && (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
      ox  = dx[OX_W-1:0];
      oy  = dy[OY_W-1:0];
   end
endmodule

// File: rtl/enemy_sprite_scheduler.sv
// Arbitrates one shared sprite ROM among enemies: priority pick, address, ROM-latency alignment,
// animation mirroring and per-frame overlap reporting.
module enemy_sprite_scheduler
   import enemy_sched_pkg::*;
#(
   parameter int  NUM_SPR     = 4,
   parameter int  TRANSP_IDX  = 0,
   parameter int  ANIM_FRAMES = 15,
   localparam int ADDR_W      = $clog2(NUM_SPR*SPR_W*SPR_H),
   localparam int ID_W        = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
)
(
   input  logic                    vga_clk,
   input  logic                    Reset,
   input  logic [9:0]              DrawX,
   input  logic [9:0]              DrawY,
   input  logic                    blank,
   input  logic                    frame_start,
   input  logic [NUM_SPR-1:0][9:0] spr_x,
   input  logic [NUM_SPR-1:0][9:0] spr_y,
   input  logic [NUM_SPR-1:0]      spr_en,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [IDX_W-1:0]        rom_q,
   output logic                    pix_valid,
   output logic [IDX_W-1:0]        pix_idx,
   output logic [ID_W-1:0]         pix_id,
   output logic                    anim_flip,
   output logic [NUM_SPR-1:0]      coll_mask
);
   localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   spr_pos_t                     shadow [NUM_SPR];
   logic [NUM_SPR-1:0]           hit;
   logic [NUM_SPR-1:0][OX_W-1:0] ox;
   logic [NUM_SPR-1:0][OY_W-1:0] oy;
   logic                         hit_any;
   logic [ID_W-1:0]              win;
   logic [OX_W-1:0]              ox_sel;
   logic [NUM_SPR-1:0]           coll_term;
   logic [NUM_SPR-1:0]           coll_acc;
   logic [CNT_W-1:0]             frame_cnt;
   logic                         hit_d;
   logic                         blank_d;
   logic [ID_W-1:0]              win_d;
   logic                         opaque;

   function automatic logic multi_hit(input logic [NUM_SPR-1:0] v);
      return (v & (v - NUM_SPR'(1))) != {NUM_SPR{1'b0}};
   endfunction

   for (genvar i = 0; i < NUM_SPR; i++) begin : g_hit
      sprite_hit_unit u_hit (
         .DrawX (DrawX),
         .DrawY (DrawY),
         .pos   (shadow[i]),
         .hit   (hit[i]),
         .ox    (ox[i]),
         .oy    (oy[i])
      );
   end

   // Game-side positions are only taken at frame_start so a frame never tears.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_SPR; i++) shadow[i] <= '{x: 10'd0, y: 10'd0, en: 1'b0};
      end else if (frame_start) begin
         for (int i = 0; i < NUM_SPR; i++) shadow[i] <= '{x: spr_x[i], y: spr_y[i], en: spr_en[i]};
      end
   end

   // Lowest index wins; scanning downward lets the last hit seen be the winner.
   always_comb begin
      hit_any = 1'b0;
      win     = {ID_W{1'b0}};
      for (int i = NUM_SPR - 1; i >= 0; i--) begin
         hit_any = hit_any | hit[i];
         win     = hit[i] ? ID_W'(i) : win;
      end
   end

   // Mirrored animation frames read columns right-to-left.
   always_comb begin
      if (anim_flip) begin
         ox_sel = OX_W'(SPR_W - 1) - ox[win];
      end else begin
         ox_sel = ox[win];
      end
      rom_addr  = hit_any ? ADDR_W'({win, oy[win], ox_sel}) : {ADDR_W{1'b0}};
      coll_term = (blank && multi_hit(hit)) ? hit : {NUM_SPR{1'b0}};
   end

   assign opaque = hit_d & blank_d & (rom_q != IDX_W'(TRANSP_IDX));

   // Stage 1 waits out the ROM read; stage 2 combines metadata with the returned index.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         hit_d     <= 1'b0;
         blank_d   <= 1'b0;
         win_d     <= {ID_W{1'b0}};
         pix_valid <= 1'b0;
         pix_idx   <= {IDX_W{1'b0}};
         pix_id    <= {ID_W{1'b0}};
      end else begin
         hit_d     <= hit_any;
         blank_d   <= blank;
         win_d     <= win;
         pix_valid <= opaque;
         pix_idx   <= opaque ? rom_q : {IDX_W{1'b0}};
         pix_id    <= win_d;
      end
   end

   // Frame-rate housekeeping: animation step counter and overlap accumulation.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         frame_cnt <= {CNT_W{1'b0}};
         anim_flip <= 1'b0;
         coll_acc  <= {NUM_SPR{1'b0}};
         coll_mask <= {NUM_SPR{1'b0}};
      end else if (frame_start) begin
         coll_mask <= coll_acc | coll_term;
         coll_acc  <= {NUM_SPR{1'b0}};
         if (frame_cnt == CNT_W'(ANIM_FRAMES - 1)) begin
            frame_cnt <= {CNT_W{1'b0}};
            anim_flip <= ~anim_flip;
         end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
         end
      end else begin
         coll_acc <= coll_acc | coll_term;
      end
   end
endmodule

// File: tb/tb_enemy_sprite_scheduler.sv
// Scoreboard bench: a pixel-level reference model queues expected results; monitors compare them.
module tb_enemy_sprite_scheduler;
   localparam int N = 4;

   logic              vga_clk = 1'b0;
   logic              Reset;
   logic [9:0]        DrawX, DrawY;
   logic              blank, frame_start;
   logic [N-1:0][9:0] spr_x, spr_y;
   logic [N-1:0]      spr_en;
   logic [11:0]       rom_addr;
   logic [3:0]        rom_q;
   logic              pix_valid;
   logic [3:0]        pix_idx;
   logic [1:0]        pix_id;
   logic              anim_flip;
   logic [N-1:0]      coll_mask;

   enemy_sprite_scheduler #(.NUM_SPR(N), .TRANSP_IDX(0), .ANIM_FRAMES(15)) dut (
      .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .frame_start(frame_start), .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en),
      .rom_addr(rom_addr), .rom_q(rom_q), .pix_valid(pix_valid), .pix_idx(pix_idx),
      .pix_id(pix_id), .anim_flip(anim_flip), .coll_mask(coll_mask)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic int rom_img(input int a);
      return ((a / 1024) * 3 + (a % 1024)) % 16;
   endfunction

   always @(posedge vga_clk) rom_q <= 4'(rom_img(int'(rom_addr)));

   typedef struct { int due; bit valid; int idx; int id; bit chk_id; } pix_exp_t;
   typedef struct { int due; bit flip; bit [N-1:0] mask; } st_exp_t;
   typedef struct { int due; int addr; } addr_exp_t;
   pix_exp_t  pq[$];
   st_exp_t   sq[$];
   addr_exp_t aq[$];
   pix_exp_t  pe;
   st_exp_t   se;
   addr_exp_t ae;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   // reference model state
   int       m_x[N], m_y[N];
   bit       m_en[N];
   bit       m_flip = 0;
   int       m_cnt = 0;
   bit [N-1:0] m_acc = '0, m_mask = '0;
   // game-side sprite values to present at the next drive
   int       nx[N], ny[N];
   bit       nen[N];

   always @(posedge vga_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge vga_clk) begin
      #1;
      while (pq.size() > 0 && pq[0].due <= cyc) begin
         pe = pq.pop_front();
         check("pix_due", pe.due, cyc);
         check("pix_valid", int'(pix_valid), int'(pe.valid));
         check("pix_idx", int'(pix_idx), pe.idx);
         if (pe.chk_id) check("pix_id", int'(pix_id), pe.id);
      end
      while (sq.size() > 0 && sq[0].due <= cyc) begin
         se = sq.pop_front();
         check("state_due", se.due, cyc);
         check("anim_flip", int'(anim_flip), int'(se.flip));
         check("coll_mask", int'(coll_mask), int'(se.mask));
      end
   end

   always @(negedge vga_clk) begin
      #2;
      while (aq.size() > 0 && aq[0].due <= cyc) begin
         ae = aq.pop_front();
         check("addr_due", ae.due, cyc);
         check("rom_addr", int'(rom_addr), ae.addr);
      end
   end

   task automatic model_step(input bit rst, input bit fs, input bit bl, input int dx, input int dy);
      int win = -1;
      int nhit = 0;
      bit [N-1:0] hm = '0;
      int rx, ry;
      int ox = 0, oy = 0, addr = 0, idx = 0;
      pix_exp_t p;
      st_exp_t s;
      addr_exp_t a;
      for (int i = 0; i < N; i++) begin
         rx = (dx - m_x[i] + 1024) % 1024;
         ry = (dy - m_y[i] + 1024) % 1024;
         if (m_en[i] && rx < 32 && ry < 32) begin
            hm[i] = 1'b1;
            nhit++;
            if (win < 0) begin win = i; ox = rx; oy = ry; end
         end
      end
      if (win >= 0) begin
         if (m_flip) ox = 31 - ox;
         addr = win * 1024 + oy * 32 + ox;
         idx  = rom_img(addr);
      end
      a.due = cyc; a.addr = addr;
      aq.push_back(a);
      if (rst) begin
         for (int k = 0; k < pq.size(); k++) begin
            p = pq[k];
            if (p.due == cyc + 1) begin
               p.valid = 0; p.idx = 0; p.id = 0; p.chk_id = 1;
               pq[k] = p;
            end
         end
         p.due = cyc + 2; p.valid = 0; p.idx = 0; p.id = 0; p.chk_id = 1;
         pq.push_back(p);
         for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; end
         m_flip = 0; m_cnt = 0; m_acc = '0; m_mask = '0;
      end else begin
         p.due = cyc + 2;
         p.valid = (win >= 0) && bl && (idx != 0);
         p.idx = p.valid ? idx : 0;
         p.id = (win >= 0) ? win : 0;
         p.chk_id = (win >= 0);
         pq.push_back(p);
         if (fs) begin
            m_mask = m_acc | ((bl && nhit >= 2) ? hm : '0);
            m_acc = '0;
            if (m_cnt == 14) begin m_cnt = 0; m_flip = !m_flip; end
            else m_cnt++;
            for (int i = 0; i < N; i++) begin m_x[i] = nx[i]; m_y[i] = ny[i]; m_en[i] = nen[i]; end
         end else if (bl && nhit >= 2) begin
            m_acc = m_acc | hm;
         end
      end
      s.due = cyc + 1; s.flip = m_flip; s.mask = m_mask;
      sq.push_back(s);
   endtask

   task automatic drive(input bit rst, input bit fs, input bit bl, input int dx, input int dy);
      @(negedge vga_clk);
      for (int i = 0; i < N; i++) begin
         spr_x[i] = 10'(nx[i]); spr_y[i] = 10'(ny[i]); spr_en[i] = nen[i];
      end
      Reset = rst; frame_start = fs; blank = bl; DrawX = 10'(dx); DrawY = 10'(dy);
      model_step(rst, fs, bl, dx, dy);
   endtask

   task automatic set_spr(input int i, input int x, input int y, input bit en);
      nx[i] = x; ny[i] = y; nen[i] = en;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rst_r, fs_r, bl_r, dx_r, dy_r, si;
      Reset = 1'b1; frame_start = 1'b0; blank = 1'b0; DrawX = '0; DrawY = '0;
      spr_x = '0; spr_y = '0; spr_en = '0;
      for (int i = 0; i < N; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; set_spr(i, 0, 0, 0);
      end
      repeat (3) drive(1, 0, 0, 0, 0);

      // single sprite, edges and last address
      set_spr(0, 100, 50, 1);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 100, 50);
      drive(0, 0, 1, 99, 50);
      drive(0, 0, 1, 132, 50);
      drive(0, 0, 1, 131, 81);
      drive(0, 0, 0, 110, 60);

      // overlap reporting and mid-frame position changes
      set_spr(0, 200, 200, 1); set_spr(1, 200, 200, 1);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 210, 210);
      drive(0, 0, 0, 0, 0);
      set_spr(1, 500, 400, 1);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 210, 210);
      drive(0, 0, 1, 505, 405);
      set_spr(0, 600, 600, 1);
      drive(0, 0, 1, 210, 210);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 210, 210);
      drive(0, 0, 1, 600, 600);
      drive(0, 0, 0, 0, 0);

      // transparent winner hides the sprite beneath
      set_spr(0, 0, 0, 0); set_spr(1, 300, 300, 1); set_spr(2, 290, 300, 1); set_spr(3, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      drive(0, 0, 1, 313, 300);
      drive(0, 0, 1, 295, 300);

      // animation mirror after 15 frames from reset
      drive(1, 0, 0, 0, 0);
      set_spr(1, 0, 0, 0); set_spr(2, 0, 0, 0); set_spr(0, 100, 50, 1);
      repeat (15) begin
         drive(0, 1, 0, 0, 0);
         drive(0, 0, 0, 0, 0);
      end
      drive(0, 0, 1, 100, 50);
      drive(0, 0, 1, 131, 50);
      drive(0, 0, 1, 115, 70);

      // reset wins over frame_start with a visible hit
      drive(0, 0, 1, 100, 50);
      drive(1, 1, 1, 100, 50);
      drive(0, 0, 0, 0, 0);
      drive(0, 0, 1, 100, 50);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            si = $urandom_range(0, N - 1);
            set_spr(si,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 130),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 130),
                    $urandom_range(0, 4) != 0);
         end
         rst_r = ($urandom_range(0, 399) == 0);
         fs_r  = ($urandom_range(0, 24) == 0);
         bl_r  = ($urandom_range(0, 9) != 0);
         dx_r  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 170);
         dy_r  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 170);
         drive(rst_r[0], fs_r[0], bl_r[0], dx_r, dy_r);
      end
      repeat (4) drive(0, 0, 0, 0, 0);

      for (int t = 0; t < 20 && (pq.size() + sq.size() + aq.size()) > 0; t++) @(posedge vga_clk);
      #3;
      check("queue_drain", pq.size() + sq.size() + aq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
